// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream router: each accepted word is steered into the FIFO of the lane picked by in_sel.
// Latency: a word pushed at edge n is visible on its lane after edge n; there is no comb in->out path.
// Backpressure: in_ready is low only while the selected lane is full; the other lanes keep flowing.

module demux_1_4_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int OW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [W-1:0]  pop_dat,
  output logic [OW-1:0] occ
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign push_rdy = (occ != OW'(DEPTH));
  assign pop_vld  = (occ != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  // Empty lanes present zero so stale storage never leaks onto the bus.
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

module demux_1_4_stream #(
  parameter int W     = 2,
  parameter int DEPTH = 2,
  parameter int CW    = 8,
  parameter int OW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [4*OW-1:0] occ,
  output logic [CW-1:0] acc_cnt
);

  logic [3:0] lane_rdy;

  // Only the selected lane's fullness gates the input; in_valid and out_ready never feed in_ready.
  assign in_ready = lane_rdy[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    demux_1_4_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (in_valid && (in_sel == 2'(k))),
      .push_dat (in_data),
      .push_rdy (lane_rdy[k]),
      .pop_vld  (out_valid[k]),
      .pop_rdy  (out_ready[k]),
      .pop_dat  (out_data[k*W +: W]),
      .occ      (occ[k*OW +: OW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (in_valid && in_ready) begin
      acc_cnt <= acc_cnt + CW'(1);
    end
  end

endmodule
